// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serialises one byte per accept as start, LSB-first data and stop bits,
// each held for a divisor latched at accept.
module uart_tx_engine #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] baud_divisor_r,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_out,
  output logic        tx_busy,
  output logic        tx_done
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q, state_d;
  logic [13:0] cnt_q, cnt_d, div_q, div_d, last;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_out_q, tx_out_d, done_q, done_d, wrap;
  // A divisor of zero behaves as one cycle per bit.
  assign last = (div_q == 14'd0) ? 14'd0 : div_q - 14'd1;
  assign wrap = cnt_q == last;
  always_comb begin
    state_d  = state_q;
    cnt_d    = (state_q == IDLE || wrap) ? 14'd0 : cnt_q + 14'd1;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_out_d = tx_out_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d  = START;
        div_d    = baud_divisor_r;
        shift_d  = tx_data;
        tx_out_d = 1'b0;
      end
      START: if (wrap) begin
        state_d  = DATA;
        bit_d    = 3'd0;
        tx_out_d = shift_q[0];
        shift_d  = shift_q >> 1;
      end
      DATA: if (wrap) begin
        if (bit_q == 3'(DATA_BITS - 1)) begin
          state_d  = STOP;
          bit_d    = 3'd0;
          tx_out_d = 1'b1;
        end else begin
          bit_d    = bit_q + 3'd1;
          tx_out_d = shift_q[0];
          shift_d  = shift_q >> 1;
        end
      end
      STOP: if (wrap) begin
        if (bit_q == 3'(STOP_BITS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_out_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_out_q <= tx_out_d;
      done_q   <= done_d;
    end
  end
  assign tx_ready = state_q == IDLE;
  assign tx_busy  = !tx_ready;
  assign tx_out   = tx_out_q;
  assign tx_done  = done_q;
endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the data bits per frame (legal 5..8).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, giving the stop bits per frame (legal 1 or 2).
REQ-003 Port clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port baud_divisor_r  input  14  clk cycles per bit period, driven by the TX baud divisor register.
REQ-006 Port tx_data  input  8  frame payload; bits [DATA_BITS-1:0] are used, upper bits ignored.
REQ-007 Port tx_valid  input  1  producer has a byte to send.
REQ-008 Port tx_ready  output  1  engine can accept a byte this cycle.
REQ-009 Port tx_out  output  1  serial line, idle high, registered.
REQ-010 Port tx_busy  output  1  frame in progress (any state other than IDLE).
REQ-011 Port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-013 tx_ready SHALL be 1 only in IDLE, and tx_busy SHALL equal NOT tx_ready.
REQ-014 A transfer SHALL be accepted when tx_valid=1 and tx_ready=1 on a rising edge; tx_data and baud_divisor_r SHALL be latched on that edge.
REQ-015 The latched divisor SHALL govern the whole frame; baud_divisor_r changes mid-frame SHALL have no effect until the next accept.
REQ-016 The bit period SHALL be D cycles, where D is the latched divisor; D=0 SHALL be treated as D=1.
REQ-017 A 14-bit bit-cycle counter SHALL count 0..D-1, and the state or bit index SHALL advance on the cycle the counter equals D-1.
REQ-018 On accept, IDLE->START, and tx_out SHALL be 0 from the next cycle for D cycles.
REQ-019 START->DATA: the engine SHALL shift out DATA_BITS bits, LSB first, each held on tx_out for D cycles.
REQ-020 DATA->STOP after bit DATA_BITS-1: tx_out SHALL be 1 for STOP_BITS*D cycles.
REQ-021 STOP->IDLE: tx_done SHALL be 1 for exactly the first IDLE cycle, coincident with tx_ready rising.
REQ-022 Frame length SHALL be (1+DATA_BITS+STOP_BITS)*D cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-023 Back-to-back: when tx_valid is held high, the next accept SHALL occur in the first IDLE cycle, so the minimum idle-high time between frames is 1 cycle.
REQ-024 tx_valid asserted while busy SHALL be ignored; there is no buffering and no error flag.
REQ-025 tx_out SHALL be 1 in IDLE.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, and counters and shift register to 0, independent of clk.
REQ-027 Reset mid-frame SHALL abort the frame immediately with tx_out=1; no tx_done SHALL be emitted for the aborted frame.
REQ-028 After reset deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-029 Defaults, D=4, tx_data=0xA5, one-cycle tx_valid -> tx_out: 0 x4, then bits 1,0,1,0,0,1,0,1 x4 each, then 1 x4 (40 cycles); tx_done pulses once on cycle 41.
REQ-030 D=0 and D=1, tx_data=0x00 -> every bit is 1 cycle; frame is 10 cycles: 0 x9, then 1 x1.
REQ-031 tx_valid held high with data 0x55 then 0xAA, D=3 -> two 30-cycle frames separated by exactly 1 idle-high cycle; tx_done pulses twice.
REQ-032 D=8; change baud_divisor_r to 2 at cycle 20 of a frame -> current frame stays 80 cycles; the next frame uses D=2 (20 cycles).
REQ-033 reset=0 at cycle 15 of a D=4 frame -> tx_out=1 and tx_ready=1 with no clock edge required; no tx_done; a new frame sends correctly after release.
REQ-034 DATA_BITS=7, STOP_BITS=2, D=2, tx_data=0xFF -> 0 x2, 1 x14, 1 x4 (20 cycles); tx_data[7] is ignored.
